// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one repeated-addition multiplier among NREQ clients.
// Optional macro MUL_SHARE_SWAP_EN: load max(A,B) as A and min(A,B) as B to shorten the add loop.
module mul_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        a_in,
    input  logic [NREQ*W-1:0]        b_in,
    output logic [NREQ-1:0]          ack,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_prod,
    output logic                     busy,
    output logic [W-1:0]             dp_data,
    output logic                     dp_lda,
    output logic                     dp_ldb,
    output logic                     dp_clrp,
    output logic                     dp_ldp,
    output logic                     dp_decb,
    input  logic                     dp_eqz,
    input  logic [W-1:0]             dp_prod
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_ADD, S_DONE} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_gidx;
    logic [NREQ-1:0] r_ack;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_prod;
    logic            r_busy;
    logic [W-1:0]    r_dp_data;
    logic            r_dp_lda;
    logic            r_dp_ldb;
    logic            r_dp_clrp;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_idx;
    int              w_t;
    logic [W-1:0]    w_pa;
    logic [W-1:0]    w_gb;
    logic [W-1:0]    w_lda_val;
    logic [W-1:0]    w_ldb_val;
    logic [IDW-1:0]  w_next_ptr;

    // First set request at or after r_rr_ptr, wrapping at NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        w_t     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_t = int'(r_rr_ptr) + k;
            if (w_t >= NREQ) w_t = w_t - NREQ;
            w_idx = IDW'(w_t);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_pa = a_in[w_pick*W +: W];
    assign w_gb = b_in[r_gidx*W +: W];

`ifdef MUL_SHARE_SWAP_EN
    logic [W-1:0] w_pb;
    logic [W-1:0] w_ga;
    assign w_pb      = b_in[w_pick*W +: W];
    assign w_ga      = a_in[r_gidx*W +: W];
    assign w_lda_val = (w_pa >= w_pb) ? w_pa : w_pb;
    assign w_ldb_val = (w_ga >= w_gb) ? w_gb : w_ga;
`else
    assign w_lda_val = w_pa;
    assign w_ldb_val = w_gb;
`endif

    assign w_next_ptr = (r_gidx == IDW'(NREQ-1)) ? '0 : r_gidx + 1'b1;

    // Moore outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_busy      <= 1'b0;
            r_dp_data   <= '0;
            r_dp_lda    <= 1'b0;
            r_dp_ldb    <= 1'b0;
            r_dp_clrp   <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_dp_data   <= '0;
            r_dp_lda    <= 1'b0;
            r_dp_ldb    <= 1'b0;
            r_dp_clrp   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gidx    <= w_pick;
                        r_state   <= S_LOAD_A;
                        r_busy    <= 1'b1;
                        r_dp_data <= w_lda_val;
                        r_dp_lda  <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    r_state   <= S_LOAD_B;
                    r_dp_data <= w_ldb_val;
                    r_dp_ldb  <= 1'b1;
                    r_dp_clrp <= 1'b1;
                end
                S_LOAD_B: r_state <= S_ADD;
                S_ADD: begin
                    if (dp_eqz) begin
                        r_state     <= S_DONE;
                        r_ack       <= NREQ'(1) << r_gidx;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_gidx;
                        r_rsp_prod  <= dp_prod;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;
    assign busy      = r_busy;
    assign dp_data   = r_dp_data;
    assign dp_lda    = r_dp_lda;
    assign dp_ldb    = r_dp_ldb;
    assign dp_clrp   = r_dp_clrp;
    // Add strobes depend on the live B==0 flag so the loop exits without an extra add.
    assign dp_ldp    = (r_state == S_ADD) && !dp_eqz;
    assign dp_decb   = (r_state == S_ADD) && !dp_eqz;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural repeated-addition datapath attached.
// Expected latency follows MUL_SHARE_SWAP_EN when the bench is built with it.
module tb_mul_share_ctrl;
    localparam int NREQ = 4;
    localparam int W    = 16;
`ifdef MUL_SHARE_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ-1:0]   ack;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_prod;
    logic              busy;
    logic [W-1:0]      dp_data;
    logic              dp_lda, dp_ldb, dp_clrp, dp_ldp, dp_decb;
    logic              dp_eqz;
    logic [W-1:0]      dp_prod;

    int total = 0;
    int bad   = 0;

    mul_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .busy(busy), .dp_data(dp_data), .dp_lda(dp_lda), .dp_ldb(dp_ldb),
        .dp_clrp(dp_clrp), .dp_ldp(dp_ldp), .dp_decb(dp_decb),
        .dp_eqz(dp_eqz), .dp_prod(dp_prod)
    );

    always #5 clk = ~clk;

    // Multiplier datapath: A, B, P registers driven by the strobes.
    logic [W-1:0] m_a = '0, m_b = '0, m_p = '0;
    always @(posedge clk) begin
        if (dp_lda) m_a <= dp_data;
        if (dp_ldb) m_b <= dp_data;
        else if (dp_decb) m_b <= m_b - 1'b1;
        if (dp_clrp) m_p <= '0;
        else if (dp_ldp) m_p <= m_p + m_a;
    end
    assign dp_eqz  = (m_b == '0);
    assign dp_prod = m_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int a, input int b);
        int n;
        n = b;
        if (SWAP && a < b) n = a;
        return n + 4;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic wait_ack(input int limit, output int cyc, output bit saw_ldp, output bit busy_ok);
        cyc = 0; saw_ldp = 1'b0; busy_ok = 1'b1;
        while (cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            if (dp_ldp || dp_decb) saw_ldp = 1'b1;
            if (!busy) busy_ok = 1'b0;
            if (ack != '0) break;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'(ack), 0);
        check({tag, "_vld"},   32'(rsp_valid), 0);
        check({tag, "_id"},    32'(rsp_id), 0);
        check({tag, "_prod"},  32'(rsp_prod), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_data"},  32'(dp_data), 0);
        check({tag, "_strb"},  32'({dp_lda, dp_ldb, dp_clrp, dp_ldp, dp_decb}), 0);
    endtask

    // Single request from IDLE; checks response fields, latency and the one-cycle pulse.
    task automatic serve(input string tag, input int i, input int a, input int b,
                         input int prod, output bit saw_ldp, output bit busy_ok);
        int cyc;
        set_op(i, a, b);
        req[i] = 1'b1;
        wait_ack(3000, cyc, saw_ldp, busy_ok);
        req[i] = 1'b0;
        check({tag, "_ack"},  32'(ack), 32'(1 << i));
        check({tag, "_vld"},  32'(rsp_valid), 1);
        check({tag, "_id"},   32'(rsp_id), 32'(i));
        check({tag, "_prod"}, 32'(rsp_prod), 32'(prod));
        check({tag, "_lat"},  32'(cyc), 32'(exp_lat(a, b)));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'({ack, rsp_valid}), 0);
    endtask

    initial begin
        int  cyc;
        bit  saw, bok;
        bit  ack_seen;
        int  order_id [4];
        int  order_pr [4];

        // Reset state
        #2;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 0);

        // All four request together; grant order 0..3, each drops on its ack
        set_op(0, 2, 3); set_op(1, 4, 5); set_op(2, 6, 7); set_op(3, 8, 1);
        order_id = '{0, 1, 2, 3};
        order_pr = '{6, 20, 42, 8};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(100, cyc, saw, bok);
            check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(order_id[k]));
            check($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << order_id[k]));
            check($sformatf("rr%0d_prod", k), 32'(rsp_prod), 32'(order_pr[k]));
            req[order_id[k]] = 1'b0;
        end
        @(posedge clk); #1;

        // Pointer back at 0: requesters 0 and 3 together -> 0 then 3
        set_op(0, 3, 4); set_op(3, 5, 6);
        req = 4'b1001;
        wait_ack(100, cyc, saw, bok);
        check("p03_first", 32'(rsp_id), 0);
        check("p03_first_prod", 32'(rsp_prod), 12);
        req[0] = 1'b0;
        wait_ack(100, cyc, saw, bok);
        check("p03_second", 32'(rsp_id), 3);
        check("p03_second_prod", 32'(rsp_prod), 30);
        req[3] = 1'b0;
        @(posedge clk); #1;

        // 17 x 10
        serve("m17x10", 0, 17, 10, 170, saw, bok);
        check("m17x10_busy", 32'(bok), 1);

        // B = 0: no add strobes, product 0, latency 4
        serve("m55x0", 1, 55, 0, 0, saw, bok);
        check("m55x0_noadd", 32'(saw), 0);

        // Wrapping overflow: 90000 mod 65536
        serve("m300x300", 2, 300, 300, 24464, saw, bok);

        // Reset while in ADD for requester 2
        set_op(2, 9, 20);
        req = 4'b0100;
        repeat (5) @(posedge clk);
        #1;
        check("abort_inadd_busy", 32'(busy), 1);
        rst_n = 1'b0;
        req = '0;
        #1;
        check_all_zero("abort");
        ack_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack != '0 || rsp_valid) ack_seen = 1'b1;
        end
        rst_n = 1'b1;
        check("abort_noack", 32'(ack_seen), 0);

        // After reset the pointer is 0, so 2 wins over 3
        set_op(3, 7, 3);
        req = 4'b1100;
        wait_ack(100, cyc, saw, bok);
        check("rearm_id", 32'(rsp_id), 2);
        check("rearm_prod", 32'(rsp_prod), 180);
        check("rearm_lat", 32'(cyc), 32'(exp_lat(9, 20)));
        req[2] = 1'b0;
        wait_ack(100, cyc, saw, bok);
        check("rearm_next_id", 32'(rsp_id), 3);
        check("rearm_next_prod", 32'(rsp_prod), 21);
        req[3] = 1'b0;
        @(posedge clk); #1;

        // Long B: latency 1004, or 6 when operands are swapped
        serve("m2x1000", 1, 2, 1000, 2000, saw, bok);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
